// File: rtl/wb_queue.sv
`default_nettype none
// ============================================================================
// Module   : wb_queue
// Purpose  : Write-back FIFO owning the register file write port, with an
//            optional decode bypass lookup (enabled by macro WB_BYPASS_EN).
// Revision : 1.0 - initial release
// ============================================================================

module wb_queue #(
    parameter int DEPTH = 4,
    parameter int CW    = $clog2(DEPTH) + 1
) (
    input  logic          clk,
    input  logic          rstd,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [4:0]    in_addr,
    input  logic [31:0]   in_data,
    input  logic          stall,
    output logic [31:0]   wr,
    output logic [4:0]    wa,
    output logic          wren,
    input  logic [4:0]    ra1,
    input  logic [4:0]    ra2,
    output logic          byp1_hit,
    output logic          byp2_hit,
    output logic [31:0]   byp1_data,
    output logic [31:0]   byp2_data,
    output logic [CW-1:0] count
);

    localparam int          PW      = $clog2(DEPTH);
    localparam logic [CW-1:0] C_DEPTH = CW'(DEPTH);

    logic [4:0]    mem_addr_q [DEPTH];
    logic [31:0]   mem_data_q [DEPTH];
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic [31:0]   wr_q, wr_d;
    logic [4:0]    wa_q, wa_d;
    logic          wren_q, wren_d;

    logic accept;
    logic push;
    logic pop;

    assign in_ready = (count_q < C_DEPTH);
    assign accept   = in_valid && in_ready;
    // Writes to r0 complete the handshake but are dropped here.
    assign push     = accept && (in_addr != 5'd0);
    assign pop      = (count_q != '0) && !stall;

    always_comb begin
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        wr_d     = wr_q;
        wa_d     = wa_q;
        wren_d   = 1'b1;
        if (push) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
            wr_d     = mem_data_q[rd_ptr_q];
            wa_d     = mem_addr_q[rd_ptr_q];
            wren_d   = 1'b0;
        end
        case ({push, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rstd) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
            wr_q     <= '0;
            wa_q     <= '0;
            wren_q   <= 1'b1;
            for (int i = 0; i < DEPTH; i++) begin
                mem_addr_q[i] <= '0;
                mem_data_q[i] <= '0;
            end
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
            wr_q     <= wr_d;
            wa_q     <= wa_d;
            wren_q   <= wren_d;
            if (push) begin
                mem_addr_q[wr_ptr_q] <= in_addr;
                mem_data_q[wr_ptr_q] <= in_data;
            end
        end
    end

    assign wr    = wr_q;
    assign wa    = wa_q;
    assign wren  = wren_q;
    assign count = count_q;

`ifdef WB_BYPASS_EN
    // Scan oldest to newest so the youngest matching source overrides.
    function automatic logic [32:0] lookup(input logic [4:0] ra);
        logic          hit;
        logic [31:0]   data;
        logic [PW-1:0] idx;
        hit  = 1'b0;
        data = '0;
        if (ra != 5'd0) begin
            if (!wren_q && (wa_q == ra)) begin
                hit  = 1'b1;
                data = wr_q;
            end
            for (int k = 0; k < DEPTH; k++) begin
                idx = rd_ptr_q + PW'(k);
                if ((CW'(k) < count_q) && (mem_addr_q[idx] == ra)) begin
                    hit  = 1'b1;
                    data = mem_data_q[idx];
                end
            end
        end
        return {hit, data};
    endfunction

    logic [32:0] byp1_res;
    logic [32:0] byp2_res;

    always_comb begin
        byp1_res = lookup(ra1);
        byp2_res = lookup(ra2);
    end

    assign byp1_hit  = byp1_res[32];
    assign byp1_data = byp1_res[31:0];
    assign byp2_hit  = byp2_res[32];
    assign byp2_data = byp2_res[31:0];
`else
    logic unused_ra;
    assign unused_ra = ^{ra1, ra2};

    assign byp1_hit  = 1'b0;
    assign byp1_data = '0;
    assign byp2_hit  = 1'b0;
    assign byp2_data = '0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_wb_queue.sv
`default_nettype none
// ============================================================================
// Module   : tb_wb_queue
// Purpose  : Self-checking bench for wb_queue with an in-order write scoreboard.
// Revision : 1.0 - initial release
// ============================================================================

module tb_wb_queue;

    localparam int DEPTH = 4;
    localparam int CW    = $clog2(DEPTH) + 1;
`ifdef WB_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rstd;
    logic          in_valid;
    logic          in_ready;
    logic [4:0]    in_addr;
    logic [31:0]   in_data;
    logic          stall;
    logic [31:0]   wr;
    logic [4:0]    wa;
    logic          wren;
    logic [4:0]    ra1, ra2;
    logic          byp1_hit, byp2_hit;
    logic [31:0]   byp1_data, byp2_data;
    logic [CW-1:0] count;

    int n_tests = 0;
    int n_fail  = 0;
    bit mon_en  = 1'b0;

    logic [36:0] sb[$];

    always #5 clk = ~clk;

    wb_queue #(.DEPTH(DEPTH), .CW(CW)) dut (
        .clk       (clk),
        .rstd      (rstd),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_addr   (in_addr),
        .in_data   (in_data),
        .stall     (stall),
        .wr        (wr),
        .wa        (wa),
        .wren      (wren),
        .ra1       (ra1),
        .ra2       (ra2),
        .byp1_hit  (byp1_hit),
        .byp2_hit  (byp2_hit),
        .byp1_data (byp1_data),
        .byp2_data (byp2_data),
        .count     (count)
    );

    // Every write pulse must match the oldest accepted, non-r0 beat.
    always @(negedge clk) begin
        if (mon_en && wren === 1'b0) begin
            n_tests++;
            if (sb.size() == 0) begin
                n_fail++;
                $display("FAIL sb_unexpected_write: got wa=%0d wr=%h, required no write", wa, wr);
            end else begin
                logic [36:0] exp;
                exp = sb.pop_front();
                if ({wa, wr} !== exp) begin
                    n_fail++;
                    $display("FAIL sb_write: got wa=%0d wr=%h, required wa=%0d wr=%h",
                             wa, wr, exp[36:32], exp[31:0]);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic test_reset();
        rstd = 1'b0; in_valid = 1'b0; in_addr = '0; in_data = '0;
        stall = 1'b0; ra1 = 5'd5; ra2 = 5'd0;
        step();
        step();
        rstd = 1'b1;
        #1;
        n_tests++; if (count !== 3'd0)    begin n_fail++; $display("FAIL reset_count: got %0d, required 0", count); end
        n_tests++; if (wren !== 1'b1)     begin n_fail++; $display("FAIL reset_wren: got %b, required 1", wren); end
        n_tests++; if ({wa, wr} !== 37'd0) begin n_fail++; $display("FAIL reset_wa_wr: got wa=%0d wr=%h, required 0/0", wa, wr); end
        n_tests++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready: got %b, required 1", in_ready); end
        n_tests++; if (byp1_hit !== 1'b0) begin n_fail++; $display("FAIL reset_byp_hit: got %b, required 0", byp1_hit); end
        mon_en = 1'b1;
    endtask

    task automatic test_single_write();
        in_valid = 1'b1; in_addr = 5'd5; in_data = 32'hDEADBEEF;
        sb.push_back({5'd5, 32'hDEADBEEF});
        step();
        in_valid = 1'b0;
        n_tests++; if (count !== 3'd1 || wren !== 1'b1) begin n_fail++; $display("FAIL single_accepted: got count=%0d wren=%b, required 1/1", count, wren); end
        step();
        n_tests++; if (wren !== 1'b0 || wa !== 5'd5 || wr !== 32'hDEADBEEF) begin n_fail++; $display("FAIL single_write: got wren=%b wa=%0d wr=%h, required 0/5/deadbeef", wren, wa, wr); end
        n_tests++; if (count !== 3'd0) begin n_fail++; $display("FAIL single_count: got %0d, required 0", count); end
        step();
        n_tests++; if (wren !== 1'b1) begin n_fail++; $display("FAIL single_one_pulse: got wren=%b, required 1", wren); end
    endtask

    task automatic test_fill_full();
        stall = 1'b1;
        for (int a = 1; a <= 4; a++) begin
            in_valid = 1'b1; in_addr = 5'(a); in_data = 32'h100 + 32'(a);
            sb.push_back({5'(a), 32'h100 + 32'(a)});
            step();
        end
        in_addr = 5'd5; in_data = 32'h105;
        n_tests++; if (in_ready !== 1'b0 || count !== 3'd4) begin n_fail++; $display("FAIL full_flag: got in_ready=%b count=%0d, required 0/4", in_ready, count); end
        step();
        n_tests++; if (in_ready !== 1'b0 || count !== 3'd4 || wren !== 1'b1) begin n_fail++; $display("FAIL full_stalled: got in_ready=%b count=%0d wren=%b, required 0/4/1", in_ready, count, wren); end
        stall = 1'b0;
        step();
        n_tests++; if (in_ready !== 1'b1 || count !== 3'd3) begin n_fail++; $display("FAIL full_slot_freed: got in_ready=%b count=%0d, required 1/3", in_ready, count); end
        sb.push_back({5'd5, 32'h105});
        for (int k = 1; k <= 5; k++) begin
            if (k > 1) in_valid = 1'b0;
            n_tests++;
            if (wren !== 1'b0 || wa !== 5'(k)) begin n_fail++; $display("FAIL full_drain_%0d: got wren=%b wa=%0d, required 0/%0d", k, wren, wa, k); end
            step();
        end
        n_tests++; if (wren !== 1'b1 || count !== 3'd0) begin n_fail++; $display("FAIL full_drained: got wren=%b count=%0d, required 1/0", wren, count); end
    endtask

    task automatic test_reg0();
        in_valid = 1'b1; in_addr = 5'd0; in_data = 32'h1234; ra1 = 5'd0;
        #1;
        n_tests++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reg0_ready: got %b, required 1", in_ready); end
        step();
        in_valid = 1'b0;
        n_tests++; if (count !== 3'd0 || wren !== 1'b1) begin n_fail++; $display("FAIL reg0_dropped: got count=%0d wren=%b, required 0/1", count, wren); end
        n_tests++; if (byp1_hit !== 1'b0 || byp1_data !== 32'd0) begin n_fail++; $display("FAIL reg0_bypass: got hit=%b data=%h, required 0/0", byp1_hit, byp1_data); end
        step();
        n_tests++; if (wren !== 1'b1) begin n_fail++; $display("FAIL reg0_no_write: got wren=%b, required 1", wren); end
    endtask

    task automatic test_bypass();
        stall = 1'b1;
        in_valid = 1'b1; in_addr = 5'd7; in_data = 32'hA;
        sb.push_back({5'd7, 32'hA});
        step();
        in_data = 32'hB;
        sb.push_back({5'd7, 32'hB});
        step();
        in_valid = 1'b0;
        ra1 = 5'd7; ra2 = 5'd8;
        #1;
        n_tests++; if (byp1_hit !== BYP || byp1_data !== (BYP ? 32'hB : 32'h0)) begin n_fail++; $display("FAIL byp_newest: got hit=%b data=%h, required %b/%h", byp1_hit, byp1_data, BYP, BYP ? 32'hB : 32'h0); end
        n_tests++; if (byp2_hit !== 1'b0 || byp2_data !== 32'd0) begin n_fail++; $display("FAIL byp_miss: got hit=%b data=%h, required 0/0", byp2_hit, byp2_data); end
        ra2 = 5'd9; in_valid = 1'b1; in_addr = 5'd9; in_data = 32'h99;
        #1;
        n_tests++; if (byp2_hit !== 1'b0) begin n_fail++; $display("FAIL byp_incoming_hidden: got hit=%b, required 0", byp2_hit); end
        in_valid = 1'b0;
        stall = 1'b0;
        step();
        n_tests++; if (byp1_hit !== BYP || byp1_data !== (BYP ? 32'hB : 32'h0)) begin n_fail++; $display("FAIL byp_after_pop: got hit=%b data=%h, required %b/%h", byp1_hit, byp1_data, BYP, BYP ? 32'hB : 32'h0); end
        step();
        n_tests++; if (byp1_hit !== BYP || byp1_data !== (BYP ? 32'hB : 32'h0)) begin n_fail++; $display("FAIL byp_outreg: got hit=%b data=%h, required %b/%h", byp1_hit, byp1_data, BYP, BYP ? 32'hB : 32'h0); end
        step();
        n_tests++; if (byp1_hit !== 1'b0 || byp1_data !== 32'd0) begin n_fail++; $display("FAIL byp_cleared: got hit=%b data=%h, required 0/0", byp1_hit, byp1_data); end
    endtask

    task automatic test_reset_mid();
        stall = 1'b1;
        for (int a = 10; a <= 12; a++) begin
            in_valid = 1'b1; in_addr = 5'(a); in_data = 32'(a);
            step();
        end
        in_valid = 1'b0;
        n_tests++; if (count !== 3'd3) begin n_fail++; $display("FAIL rstmid_queued: got %0d, required 3", count); end
        rstd = 1'b0;
        step();
        rstd = 1'b1;
        n_tests++; if (count !== 3'd0 || wren !== 1'b1) begin n_fail++; $display("FAIL rstmid_cleared: got count=%0d wren=%b, required 0/1", count, wren); end
        stall = 1'b0;
        for (int k = 0; k < 4; k++) begin
            step();
            n_tests++; if (wren !== 1'b1) begin n_fail++; $display("FAIL rstmid_no_write_%0d: got wren=%b, required 1", k, wren); end
        end
    endtask

    task automatic test_back_to_back();
        logic [4:0] addrs [8];
        stall = 1'b0;
        for (int i = 0; i < 8; i++) begin
            addrs[i] = 5'(16 + i);
            in_valid = 1'b1; in_addr = addrs[i]; in_data = $urandom;
            sb.push_back({in_addr, in_data});
            step();
            if (i >= 1) begin
                n_tests++;
                if (count !== 3'd1 || wren !== 1'b0 || wa !== addrs[i-1]) begin
                    n_fail++;
                    $display("FAIL b2b_%0d: got count=%0d wren=%b wa=%0d, required 1/0/%0d", i, count, wren, wa, addrs[i-1]);
                end
            end
        end
        in_valid = 1'b0;
        step();
        n_tests++; if (count !== 3'd0 || wren !== 1'b0 || wa !== addrs[7]) begin n_fail++; $display("FAIL b2b_last: got count=%0d wren=%b wa=%0d, required 0/0/%0d", count, wren, wa, addrs[7]); end
        step();
        n_tests++; if (wren !== 1'b1) begin n_fail++; $display("FAIL b2b_idle: got wren=%b, required 1", wren); end
    endtask

    initial begin
        test_reset();
        test_single_write();
        test_fill_full();
        test_reg0();
        test_bypass();
        test_reset_mid();
        test_back_to_back();
        step();
        n_tests++; if (sb.size() != 0) begin n_fail++; $display("FAIL sb_drained: got %0d pending, required 0", sb.size()); end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
